// File: rtl/pcie_ss_axis_rx_pkt_arb.sv
// Packet-granular two-port arbiter merging the RX completion (port 0) and request (port 1)
// TLP streams. Completions get weighted priority; a burst limit bounds request starvation.
module pcie_ss_axis_rx_pkt_arb #(
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 10,
    parameter int P0_BURST   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    i0_tvalid,
    output logic                    i0_tready,
    input  logic [DATA_WIDTH-1:0]   i0_tdata,
    input  logic [DATA_WIDTH/8-1:0] i0_tkeep,
    input  logic [USER_WIDTH-1:0]   i0_tuser_vendor,
    input  logic                    i0_tlast,

    input  logic                    i1_tvalid,
    output logic                    i1_tready,
    input  logic [DATA_WIDTH-1:0]   i1_tdata,
    input  logic [DATA_WIDTH/8-1:0] i1_tkeep,
    input  logic [USER_WIDTH-1:0]   i1_tuser_vendor,
    input  logic                    i1_tlast,

    output logic                    o_tvalid,
    input  logic                    o_tready,
    output logic [DATA_WIDTH-1:0]   o_tdata,
    output logic [DATA_WIDTH/8-1:0] o_tkeep,
    output logic [USER_WIDTH-1:0]   o_tuser_vendor,
    output logic                    o_tlast,
    output logic                    o_src,
    output logic                    busy
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    typedef struct packed {
        logic                  src;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
        logic [KEEP_WIDTH-1:0] keep;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    state_t     state_q, state_d;
    logic [7:0] burst_cnt;
    logic       arb_en;
    beat_t      head_q, skid_q, in_beat;
    logic       head_vld, skid_vld;
    logic       pop, space, grant, grant_vld, in_valid, push, sop;

    // Grant selection: arbitration in IDLE, fixed to the locked port otherwise.
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant     = 1'b0;
        grant_vld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i0_tvalid && i1_tvalid) begin
                    grant_vld = 1'b1;
                    grant     = (burst_cnt == 8'(P0_BURST));
                end else if (i0_tvalid) begin
                    grant_vld = 1'b1;
                end else if (i1_tvalid) begin
                    grant_vld = 1'b1;
                    grant     = 1'b1;
                end
            end
            LOCK0: grant_vld = 1'b1;
            LOCK1: begin
                grant_vld = 1'b1;
                grant     = 1'b1;
            end
            default: ;
        endcase
    end

    assign pop       = head_vld & o_tready;
    assign space     = ~skid_vld | pop;
    assign i0_tready = arb_en & space & grant_vld & ~grant;
    assign i1_tready = arb_en & space & grant_vld & grant;
    assign in_valid  = grant ? i1_tvalid : i0_tvalid;
    assign push      = arb_en & space & grant_vld & in_valid;
    assign sop       = push & (state_q == IDLE);

    always_comb begin
        in_beat.src  = grant;
        in_beat.last = grant ? i1_tlast        : i0_tlast;
        in_beat.user = grant ? i1_tuser_vendor : i0_tuser_vendor;
        in_beat.keep = grant ? i1_tkeep        : i0_tkeep;
        in_beat.data = grant ? i1_tdata        : i0_tdata;
    end

    always_comb begin
        state_d = state_q;
        if (push) begin
            if (in_beat.last) state_d = IDLE;
            else              state_d = grant ? LOCK1 : LOCK0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            burst_cnt <= 8'd0;
            arb_en    <= 1'b0;
        end else begin
            state_q <= state_d;
            arb_en  <= 1'b1;
            if (sop) begin
                if (grant)
                    burst_cnt <= 8'd0;
                else if (i1_tvalid && burst_cnt != 8'(P0_BURST))
                    burst_cnt <= burst_cnt + 8'd1;
            end
        end
    end

    // Two-entry skid buffer: head drives the outputs directly, skid absorbs one stalled beat.
    // NOTE: payload registers are reset too, because every output must read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            skid_q   <= '0;
            head_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (pop) begin
            if (skid_vld) begin
                head_q <= skid_q;
                if (push) skid_q   <= in_beat;
                else      skid_vld <= 1'b0;
            end else if (push) begin
                head_q <= in_beat;
            end else begin
                head_vld <= 1'b0;
            end
        end else if (push) begin
            if (head_vld) begin
                skid_q   <= in_beat;
                skid_vld <= 1'b1;
            end else begin
                head_q   <= in_beat;
                head_vld <= 1'b1;
            end
        end
    end

    assign o_tvalid       = head_vld;
    assign o_tdata        = head_q.data;
    assign o_tkeep        = head_q.keep;
    assign o_tuser_vendor = head_q.user;
    assign o_tlast        = head_q.last;
    assign o_src          = head_q.src;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_pcie_ss_axis_rx_pkt_arb.sv
// Directed self-checking bench for pcie_ss_axis_rx_pkt_arb: per-port scoreboard plus
// hand-computed grant sequences, latency, lock, reset and stall-stability checks.
module tb_pcie_ss_axis_rx_pkt_arb;

    localparam int DW    = 512;
    localparam int KW    = DW / 8;
    localparam int UW    = 10;
    localparam int BURST = 2;

    logic          clk, rst_n;
    logic          i0_tvalid, i0_tready, i0_tlast;
    logic [DW-1:0] i0_tdata;
    logic [KW-1:0] i0_tkeep;
    logic [UW-1:0] i0_tuser_vendor;
    logic          i1_tvalid, i1_tready, i1_tlast;
    logic [DW-1:0] i1_tdata;
    logic [KW-1:0] i1_tkeep;
    logic [UW-1:0] i1_tuser_vendor;
    logic          o_tvalid, o_tready, o_tlast, o_src, busy;
    logic [DW-1:0] o_tdata;
    logic [KW-1:0] o_tkeep;
    logic [UW-1:0] o_tuser_vendor;

    typedef struct packed {
        logic [23:0] tag;
        logic        last;
    } beat_t;

    beat_t       q0[$], q1[$], exp0[$], exp1[$];
    logic [23:0] out_tag[$];
    logic        out_src[$], out_busy[$];
    int          out_cyc[$], fire_cyc0[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          gaps = 0;
    bit          rdy_rand = 0;

    pcie_ss_axis_rx_pkt_arb #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .P0_BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .i0_tvalid(i0_tvalid), .i0_tready(i0_tready), .i0_tdata(i0_tdata), .i0_tkeep(i0_tkeep),
        .i0_tuser_vendor(i0_tuser_vendor), .i0_tlast(i0_tlast),
        .i1_tvalid(i1_tvalid), .i1_tready(i1_tready), .i1_tdata(i1_tdata), .i1_tkeep(i1_tkeep),
        .i1_tuser_vendor(i1_tuser_vendor), .i1_tlast(i1_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata), .o_tkeep(o_tkeep),
        .o_tuser_vendor(o_tuser_vendor), .o_tlast(o_tlast), .o_src(o_src), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] mk_tag(input int port, input int pkt, input int beat);
        return {4'(port), 12'(pkt), 8'(beat)};
    endfunction

    task automatic send_pkt(input int port, input int pkt, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.tag  = mk_tag(port, pkt, i);
            b.last = (i == n - 1);
            if (port == 0) q0.push_back(b);
            else           q1.push_back(b);
        end
    endtask

    task automatic clear_log();
        out_tag.delete();
        out_src.delete();
        out_busy.delete();
        out_cyc.delete();
        fire_cyc0.delete();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while ((q0.size() + q1.size() + exp0.size() + exp1.size()) != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_drained"}, 64'(q0.size() + q1.size() + exp0.size() + exp1.size()), 64'd0);
        @(negedge clk);
    endtask

    // Port drivers: hold a presented beat until it transfers, then present the next one.
    initial begin : drv0
        bit    fire;
        beat_t b;
        i0_tvalid = 1'b0; i0_tdata = '0; i0_tkeep = '0; i0_tuser_vendor = '0; i0_tlast = 1'b0;
        forever begin
            @(negedge clk);
            fire = rst_n && i0_tvalid && i0_tready;
            if (fire) begin
                fire_cyc0.push_back(cyc);
                exp0.push_back(q0.pop_front());
            end
            @(posedge clk);
            #1;
            if (!rst_n) i0_tvalid = 1'b0;
            else if (fire || !i0_tvalid) begin
                if (q0.size() != 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                    b = q0[0];
                    i0_tvalid = 1'b1; i0_tdata = DW'(b.tag); i0_tkeep = KW'(b.tag);
                    i0_tuser_vendor = b.tag[UW-1:0]; i0_tlast = b.last;
                end else begin
                    i0_tvalid = 1'b0;
                end
            end
        end
    end

    initial begin : drv1
        bit    fire;
        beat_t b;
        i1_tvalid = 1'b0; i1_tdata = '0; i1_tkeep = '0; i1_tuser_vendor = '0; i1_tlast = 1'b0;
        forever begin
            @(negedge clk);
            fire = rst_n && i1_tvalid && i1_tready;
            if (fire) exp1.push_back(q1.pop_front());
            @(posedge clk);
            #1;
            if (!rst_n) i1_tvalid = 1'b0;
            else if (fire || !i1_tvalid) begin
                if (q1.size() != 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                    b = q1[0];
                    i1_tvalid = 1'b1; i1_tdata = DW'(b.tag); i1_tkeep = KW'(b.tag);
                    i1_tuser_vendor = b.tag[UW-1:0]; i1_tlast = b.last;
                end else begin
                    i1_tvalid = 1'b0;
                end
            end
        end
    end

    initial begin : rdy_drv
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard per source port and stability while stalled.
    initial begin : mon
        logic [63:0] snap, prev;
        bit          stalled;
        beat_t       e;
        int          n;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            snap = {3'b0, o_tdata[23:0], o_tkeep[23:0], o_tuser_vendor, o_tlast, o_src, o_tvalid};
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("stall_stable", snap, prev);
                if (o_tvalid && o_tready) begin
                    out_tag.push_back(o_tdata[23:0]);
                    out_src.push_back(o_src);
                    out_busy.push_back(busy);
                    out_cyc.push_back(cyc);
                    n = o_src ? exp1.size() : exp0.size();
                    check("sb_has_expected", 64'(n != 0), 64'd1);
                    if (n != 0) begin
                        if (o_src) e = exp1.pop_front();
                        else       e = exp0.pop_front();
                        check("sb_tdata", o_tdata[63:0], 64'(e.tag));
                        check("sb_keep_user_last", {23'b0, o_tkeep[23:0], o_tuser_vendor, o_tlast, o_tkeep[63:58]},
                              {23'b0, e.tag, e.tag[UW-1:0], e.last, 6'b0});
                    end
                end
                stalled = o_tvalid && !o_tready;
                prev    = snap;
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : main
        int  k, cnt;
        bit  done, pushed;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_o_tvalid", 64'(o_tvalid), 64'd0);
        check("reset_i0_tready", 64'(i0_tready), 64'd0);
        check("reset_i1_tready", 64'(i1_tready), 64'd0);
        check("reset_o_src", 64'(o_src), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Port 0 alone: three 2-beat packets back to back.
        clear_log();
        for (int p = 0; p < 3; p++) send_pkt(0, 1 + p, 2);
        wait_drain("t1", 100);
        check("t1_beats", 64'(out_tag.size()), 64'd6);
        if (out_tag.size() == 6 && fire_cyc0.size() != 0) begin
            for (int i = 0; i < 6; i++) begin
                check("t1_tag", 64'(out_tag[i]), 64'(mk_tag(0, 1 + i / 2, i % 2)));
                check("t1_src", 64'(out_src[i]), 64'd0);
                check("t1_busy", 64'(out_busy[i]), 64'(i % 2 == 0));
            end
            check("t1_latency", 64'(out_cyc[0] - fire_cyc0[0]), 64'd1);
            check("t1_rate", 64'(out_cyc[5] - out_cyc[0]), 64'd5);
        end

        // Both ports always valid with single-beat packets: 0,0,1 repeating.
        clear_log();
        for (int i = 0; i < 6; i++) send_pkt(0, 10 + i, 1);
        for (int i = 0; i < 3; i++) send_pkt(1, 20 + i, 1);
        wait_drain("t2", 100);
        check("t2_beats", 64'(out_src.size()), 64'd9);
        if (out_src.size() == 9) begin
            for (int i = 0; i < 9; i++) check("t2_src_seq", 64'(out_src[i]), 64'(i % 3 == 2));
            check("t2_rate", 64'(out_cyc[8] - out_cyc[0]), 64'd8);
        end

        // Port 1 locked over 4 beats; port 0 arrives mid-packet and must wait.
        clear_log();
        send_pkt(1, 30, 4);
        k = 0; done = 1'b0; pushed = 1'b0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            if (i1_tvalid && i1_tready) begin
                if (!pushed) begin
                    send_pkt(0, 31, 2);
                    pushed = 1'b1;
                end
                if (i1_tlast) done = 1'b1;
            end
            if (pushed) check("t3_i0_tready_locked", 64'(i0_tready), 64'd0);
        end
        check("t3_lock_done", 64'(done), 64'd1);
        wait_drain("t3", 100);
        check("t3_beats", 64'(out_tag.size()), 64'd6);
        if (out_tag.size() == 6) begin
            for (int i = 0; i < 4; i++) check("t3_p1_tag", 64'(out_tag[i]), 64'(mk_tag(1, 30, i)));
            for (int i = 0; i < 2; i++) check("t3_p0_tag", 64'(out_tag[4 + i]), 64'(mk_tag(0, 31, i)));
        end

        // Random backpressure and valid gaps over 200 packets.
        gaps = 1'b1;
        rdy_rand = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send_pkt(0, 100 + i, 1 + int'($urandom_range(0, 3)));
            send_pkt(1, 100 + i, 1 + int'($urandom_range(0, 3)));
        end
        wait_drain("t4", 20000);
        gaps = 1'b0;
        rdy_rand = 1'b0;
        repeat (2) @(negedge clk);

        // Reset at beat 2 of a 5-beat packet while port 1 waits (burst_cnt becomes 1).
        clear_log();
        send_pkt(0, 50, 5);
        send_pkt(1, 51, 1);
        k = 0; cnt = 0;
        while (cnt < 2 && k < 50) begin
            @(negedge clk);
            k++;
            if (i0_tvalid && i0_tready) cnt++;
        end
        check("t5_two_beats", 64'(cnt), 64'd2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
        #1;
        check("t5_rst_o_tvalid", 64'(o_tvalid), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_i0_tready", 64'(i0_tready), 64'd0);
        check("t5_rst_i1_tready", 64'(i1_tready), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_log();
        for (int i = 0; i < 3; i++) send_pkt(0, 52 + i, 1);
        send_pkt(1, 55, 1);
        wait_drain("t5", 100);
        check("t5_beats", 64'(out_src.size()), 64'd4);
        if (out_src.size() == 4) begin
            check("t5_src0", 64'(out_src[0]), 64'd0);
            check("t5_src1", 64'(out_src[1]), 64'd0);
            check("t5_src2", 64'(out_src[2]), 64'd1);
            check("t5_src3", 64'(out_src[3]), 64'd0);
        end

        // Port 1 alone for 10 packets, then port 0 must be granted at once.
        clear_log();
        for (int i = 0; i < 10; i++) send_pkt(1, 60 + i, 1);
        wait_drain("t6", 200);
        check("t6_beats", 64'(out_src.size()), 64'd10);
        foreach (out_src[i]) check("t6_src", 64'(out_src[i]), 64'd1);
        send_pkt(0, 70, 1);
        k = 0;
        while (!i0_tvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t6_p0_valid_seen", 64'(i0_tvalid), 64'd1);
        check("t6_p0_ready_now", 64'(i0_tready), 64'd1);
        wait_drain("t6b", 100);
        clear_log();
        for (int i = 0; i < 3; i++) send_pkt(0, 71 + i, 1);
        send_pkt(1, 74, 1);
        wait_drain("t6c", 100);
        check("t6_beats_mix", 64'(out_src.size()), 64'd4);
        if (out_src.size() == 4) begin
            check("t6_src0", 64'(out_src[0]), 64'd0);
            check("t6_src1", 64'(out_src[1]), 64'd0);
            check("t6_src2", 64'(out_src[2]), 64'd1);
            check("t6_src3", 64'(out_src[3]), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pcie_ss_axis_rx_pkt_arb.md
Name: pcie_ss_axis_rx_pkt_arb

Overview:
Packet-granular arbiter that shares one PCIe SS RX AXI-S TLP stream between two sources. Port 0 carries completions; port 1 carries requests. It sits downstream of the RX segment-align stage, so both inputs carry in-band headers with at most one header (SOP) per cycle. It merges them toward the RX split/demux logic. Completions get weighted priority, and a burst limit bounds starvation of requests.

Parameters:
DATA_WIDTH, 512, tdata width in bits (512/1024/2048)
USER_WIDTH, 10, tuser_vendor width
P0_BURST, 4, max consecutive port-0 packets granted while port 1 is waiting; legal range 1..255

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i0_tvalid  in  1  port 0 beat valid
i0_tready  out  1  port 0 ready
i0_tdata  in  DATA_WIDTH  port 0 data
i0_tkeep  in  DATA_WIDTH/8  port 0 byte enables
i0_tuser_vendor  in  USER_WIDTH  port 0 user
i0_tlast  in  1  port 0 end of packet
i1_tvalid/i1_tready/i1_tdata/i1_tkeep/i1_tuser_vendor/i1_tlast  same widths and directions as port 0  port 1 stream
o_tvalid  out  1  merged beat valid
o_tready  in  1  downstream ready
o_tdata  out  DATA_WIDTH  merged data
o_tkeep  out  DATA_WIDTH/8  merged byte enables
o_tuser_vendor  out  USER_WIDTH  merged user
o_tlast  out  1  merged end of packet
o_src  out  1  source port of the current output beat
busy  out  1  a packet is locked mid-transfer

Behaviour:
- Reset is async assert, sync deassert (external). All outputs are 0 during reset, including o_tvalid, i*_tready, o_src and busy. The skid buffer empties, the FSM goes to IDLE and burst_cnt is cleared.
- Output stage is a 2-entry skid buffer with registered o_tvalid and payload. Input-to-output latency is 1 cycle. Sustained throughput is 1 beat/cycle when o_tready=1.
- space = skid entries free ≥1 after this cycle's pop. i*_tready is asserted only for the granted port and only when space=1. The ungranted port's i*_tready is 0.
- FSM states are IDLE, LOCK0 and LOCK1.
- IDLE, grant decision (combinational, same cycle as the first beat):
  - Only i0 valid: grant 0.
  - Only i1 valid: grant 1.
  - Both valid: grant 1 if burst_cnt==P0_BURST, otherwise grant 0.
  - Neither valid: no grant.
- A granted beat transfers when space=1.
  - If it has tlast=1, the FSM stays in IDLE, which gives a single-beat packet.
  - Otherwise the FSM moves to LOCK<g>.
- LOCKn: only port n is ready. Beats pass until the tlast beat transfers, then the FSM returns to IDLE. The other port is never interleaved, even if its tvalid rises mid-packet.
- burst_cnt (8 bit), updated on SOP transfer:
  - Port 0 granted while i1_tvalid=1: increment, saturating at P0_BURST.
  - Port 0 granted while i1_tvalid=0: unchanged.
  - Port 1 granted: clear to 0.
- busy is 1 in LOCK0/LOCK1. o_src is registered alongside the payload in the skid buffer.
- Downstream stall: o_tvalid held with o_tready=0 keeps all o_* stable. After 2 stalled beats, i*_tready drops the next cycle.
- Input tvalid may drop mid-packet. The FSM stays locked and waits; no timeout.
- Reset mid-packet drops any partial packet. After release, arbitration restarts in IDLE with burst_cnt=0.

Test Plan:
- Only port 0 sends 3 packets of 2 beats, o_tready=1. Required: 6 output beats in order, first o_tvalid 1 cycle after the first input beat, o_src=0, busy high on beats 1/3/5.
- Both ports always valid, single-beat packets, P0_BURST=2. Required: o_src sequence 0,0,1,0,0,1,0,0,1 at 1 beat/cycle.
- Port 1 sends a 4-beat packet. Port 0 asserts tvalid at beat 2. Required: all 4 port-1 beats contiguous, then the port-0 packet; i0_tready=0 throughout.
- Random o_tready (50%) and random input valid gaps over 200 packets. Required: scoreboard matches per-port order and payload, with no loss or duplication. o_* stay stable while o_tvalid=1 and o_tready=0.
- Assert rst_n=0 at beat 2 of a 5-beat packet. Required: o_tvalid=0, busy=0, i*_tready=0 immediately. The next packet after release starts cleanly with arbitration from burst_cnt=0.
- Only port 1 valid while port 0 idle, 10 packets. Required: all granted to port 1; burst_cnt stays 0, then port-0 traffic is granted immediately.
